// File: rtl/lockpick_pkg.sv
// -----------------------------------------------------------------------------
// lockpick_pkg
// Shared types and constants for the lockpick result monitor: FSM states,
// frame class encoding, frame length, the period-2 result byte patterns,
// 7-segment glyphs and small helpers that classify and regenerate patterns.
// -----------------------------------------------------------------------------
package lockpick_pkg;

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2,
      ST_REPORT  = 2'd3
   } state_t;

   // Same encoding as the game's status word, so classes compare directly.
   typedef enum logic [1:0] {
      CLS_NONE  = 2'b00,
      CLS_ERROR = 2'b01,
      CLS_WIN   = 2'b10,
      CLS_LOCK  = 2'b11
   } class_t;

   localparam int unsigned FRAME_LEN = 32;

   // Result patterns: byte at even index / byte at odd index.
   localparam logic [7:0] WIN_EVEN  = 8'hCE;
   localparam logic [7:0] WIN_ODD   = 8'hFA;
   localparam logic [7:0] ERR_EVEN  = 8'hD0;
   localparam logic [7:0] ERR_ODD   = 8'hBA;
   localparam logic [7:0] LOCK_EVEN = 8'hAD;
   localparam logic [7:0] LOCK_ODD  = 8'hDE;

   // Active-high {g,f,e,d,c,b,a} glyphs.
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_P    = 7'h73;
   localparam logic [6:0] SEG_E    = 7'h79;
   localparam logic [6:0] SEG_L    = 7'h38;
   localparam logic [6:0] SEG_U    = 7'h3E;

   // Candidate class from the first two bytes of a frame.
   function automatic class_t classify_pair(input logic [7:0] b0, input logic [7:0] b1);
      if (b0 == WIN_EVEN && b1 == WIN_ODD)   return CLS_WIN;
      if (b0 == ERR_EVEN && b1 == ERR_ODD)   return CLS_ERROR;
      if (b0 == LOCK_EVEN && b1 == LOCK_ODD) return CLS_LOCK;
      return CLS_NONE;
   endfunction

   // Byte a frame of class cls must carry at an index of the given parity.
   function automatic logic [7:0] pattern_byte(input class_t cls, input logic odd);
      case (cls)
         CLS_WIN:   return odd ? WIN_ODD  : WIN_EVEN;
         CLS_ERROR: return odd ? ERR_ODD  : ERR_EVEN;
         CLS_LOCK:  return odd ? LOCK_ODD : LOCK_EVEN;
         default:   return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/lockpick_seg7.sv
// -----------------------------------------------------------------------------
// lockpick_seg7
// Combinational 7-segment decode of the last frame class.
// Ports:
//   msg_class - last frame class (00 unrecognized, 01 error, 10 win, 11 lockout)
//   shown     - a frame has been classified since reset
//   seg       - active-high {g,f,e,d,c,b,a}; '-' until the first classification
// -----------------------------------------------------------------------------
module lockpick_seg7
   import lockpick_pkg::*;
(
   input  logic [1:0] msg_class,
   input  logic       shown,
   output logic [6:0] seg
);

   // NOTE: every output of an always_comb gets a default first so no path
   // through the case leaves it unassigned, which would infer a latch.
   always_comb begin
      seg = SEG_DASH;
      if (shown) begin
         case (class_t'(msg_class))
            CLS_WIN:   seg = SEG_P;
            CLS_ERROR: seg = SEG_E;
            CLS_LOCK:  seg = SEG_L;
            default:   seg = SEG_U;
         endcase
      end
   end

endmodule

// File: rtl/lockpick_result_monitor.sv
// -----------------------------------------------------------------------------
// lockpick_result_monitor
// Watches the lockpick game's result byte stream, collects 32-byte frames,
// classifies each frame against the period-2 result patterns, cross-checks the
// class against the game's status, keeps saturating outcome counters and shows
// the last class on a 7-segment display.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   in_valid        - result byte strobe
//   in_data         - result byte
//   in_status       - game status (01 error, 10 win, 11 lockout), sampled with byte 0
//   clear_stats     - synchronous clear of all outcome counters
//   msg_done        - one-cycle pulse marking a completed frame
//   msg_class       - last frame class, held until the next classification
//   class_mismatch  - class unrecognized or disagreeing with the sampled status
//   frame_err       - one-cycle pulse on a framing violation
//   win_count, err_count, lock_count - saturating outcome counters
//   seg             - 7-segment display of msg_class
// -----------------------------------------------------------------------------
module lockpick_result_monitor
   import lockpick_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic [1:0] in_status,
   input  logic       clear_stats,
   output logic       msg_done,
   output logic [1:0] msg_class,
   output logic       class_mismatch,
   output logic       frame_err,
   output logic [7:0] win_count,
   output logic [7:0] err_count,
   output logic [7:0] lock_count,
   output logic [6:0] seg
);

   state_t     state, state_nxt;
   logic [4:0] idx;
   logic [7:0] byte0;
   class_t     cand;
   logic       mismatch;
   logic [1:0] status_q;
   logic       shown;

   logic       accept;
   logic       abort;
   logic       overrun;
   class_t     verdict_cls;
   logic       verdict_mis;

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_WAIT;
      else     state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // Next state and per-cycle strobes
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      abort     = 1'b0;
      overrun   = 1'b0;
      case (state)
         ST_WAIT: begin
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (in_valid) begin
               accept = 1'b1;
               if (idx == 5'(FRAME_LEN - 1)) state_nxt = ST_CHECK;
            end else begin
               // A gap inside a frame breaks it; the partial frame is dropped.
               abort     = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_CHECK: begin
            overrun   = in_valid;
            state_nxt = ST_REPORT;
         end
         ST_REPORT: begin
            overrun   = in_valid;
            state_nxt = ST_WAIT;
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   // Final class: any deviation from the candidate pattern demotes to 00.
   assign verdict_cls = mismatch ? CLS_NONE : cand;
   assign verdict_mis = (verdict_cls == CLS_NONE) || (verdict_cls != class_t'(status_q));

   assign msg_done = (state == ST_REPORT);

   // -------------------------------------------------------------------------
   // Frame collection and classification
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= 5'd0;
         byte0          <= 8'h00;
         cand           <= CLS_NONE;
         mismatch       <= 1'b0;
         status_q       <= 2'b00;
         msg_class      <= CLS_NONE;
         class_mismatch <= 1'b0;
         frame_err      <= 1'b0;
         shown          <= 1'b0;
      end else begin
         frame_err <= abort | overrun;
         if (abort) idx <= 5'd0;

         if (accept) begin
            if (state == ST_WAIT) begin
               idx      <= 5'd1;
               byte0    <= in_data;
               status_q <= in_status;
               cand     <= CLS_NONE;
               mismatch <= 1'b0;
            end else begin
               // Wraps to 0 after the last byte, ready for the next frame.
               idx <= idx + 5'd1;
               if (idx == 5'd1) begin
                  cand <= classify_pair(byte0, in_data);
               end else if (cand != CLS_NONE && in_data != pattern_byte(cand, idx[0])) begin
                  mismatch <= 1'b1;
               end
            end
         end

         if (state == ST_CHECK) begin
            msg_class      <= verdict_cls;
            class_mismatch <= verdict_mis;
            shown          <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Saturating outcome counters; clear beats a same-cycle increment
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         win_count  <= 8'd0;
         err_count  <= 8'd0;
         lock_count <= 8'd0;
      end else if (state == ST_CHECK) begin
         case (verdict_cls)
            CLS_WIN:   if (win_count  != 8'hFF) win_count  <= win_count  + 8'd1;
            CLS_ERROR: if (err_count  != 8'hFF) err_count  <= err_count  + 8'd1;
            CLS_LOCK:  if (lock_count != 8'hFF) lock_count <= lock_count + 8'd1;
            default: ;
         endcase
      end
   end

   lockpick_seg7 u_seg7 (
      .msg_class (msg_class),
      .shown     (shown),
      .seg       (seg)
   );

endmodule

// File: tb/tb_lockpick_result_monitor.sv
// -----------------------------------------------------------------------------
// tb_lockpick_result_monitor
// Directed bench: each frame pushes its expected report onto a queue when it is
// driven; a negedge monitor pops and compares whenever msg_done pulses.
// -----------------------------------------------------------------------------
module tb_lockpick_result_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic [1:0] in_status;
   logic       clear_stats;
   logic       msg_done;
   logic [1:0] msg_class;
   logic       class_mismatch;
   logic       frame_err;
   logic [7:0] win_count;
   logic [7:0] err_count;
   logic [7:0] lock_count;
   logic [6:0] seg;

   always #5 clk = ~clk;

   lockpick_result_monitor dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_status      (in_status),
      .clear_stats    (clear_stats),
      .msg_done       (msg_done),
      .msg_class      (msg_class),
      .class_mismatch (class_mismatch),
      .frame_err      (frame_err),
      .win_count      (win_count),
      .err_count      (err_count),
      .lock_count     (lock_count),
      .seg            (seg)
   );

   typedef struct {
      logic [1:0] cls;
      logic       mis;
      logic [7:0] win;
      logic [7:0] err;
      logic [7:0] lock;
      logic [6:0] seg;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int fe_cnt   = 0;
   int fe0, d0;

   logic [7:0] m_win  = 8'd0;
   logic [7:0] m_err  = 8'd0;
   logic [7:0] m_lock = 8'd0;

   localparam int MODE_NORMAL  = 0;
   localparam int MODE_OVERRUN = 1;
   localparam int MODE_CLEAR   = 2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [1:0] c);
      case (c)
         2'b10:   return 7'h73;
         2'b01:   return 7'h79;
         2'b11:   return 7'h38;
         default: return 7'h3E;
      endcase
   endfunction

   function automatic logic [1:0] pair_cls(input logic [7:0] b0, input logic [7:0] b1);
      if (b0 == 8'hCE && b1 == 8'hFA) return 2'b10;
      if (b0 == 8'hD0 && b1 == 8'hBA) return 2'b01;
      if (b0 == 8'hAD && b1 == 8'hDE) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [7:0] pat(input logic [1:0] c, input int i);
      logic [7:0] ev, od;
      case (c)
         2'b10:   begin ev = 8'hCE; od = 8'hFA; end
         2'b01:   begin ev = 8'hD0; od = 8'hBA; end
         2'b11:   begin ev = 8'hAD; od = 8'hDE; end
         default: begin ev = 8'h00; od = 8'h00; end
      endcase
      return (i % 2 == 1) ? od : ev;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Drive one full 32-byte frame, optionally corrupting one byte, and check
   // msg_done timing: low in the CHECK cycle, high in the cycle after.
   task automatic send_frame(input logic [7:0] ev, input logic [7:0] od, input logic [1:0] st,
                             input int bad_idx, input logic [7:0] bad_val, input int mode);
      logic [7:0] b [32];
      logic [1:0] c;
      logic       mm;
      exp_t       e;
      for (int i = 0; i < 32; i++) b[i] = (i == bad_idx) ? bad_val : ((i % 2 == 1) ? od : ev);
      c  = pair_cls(b[0], b[1]);
      mm = 1'b0;
      for (int i = 2; i < 32; i++) if (c != 2'b00 && b[i] != pat(c, i)) mm = 1'b1;
      if (mm) c = 2'b00;
      if (mode == MODE_CLEAR) begin
         m_win = 8'd0; m_err = 8'd0; m_lock = 8'd0;
      end else begin
         case (c)
            2'b10:   m_win  = sat_inc(m_win);
            2'b01:   m_err  = sat_inc(m_err);
            2'b11:   m_lock = sat_inc(m_lock);
            default: ;
         endcase
      end
      e.cls  = c;
      e.mis  = (c == 2'b00) || (c != st);
      e.win  = m_win;
      e.err  = m_err;
      e.lock = m_lock;
      e.seg  = seg_of(c);
      exp_q.push_back(e);

      in_status = st;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_data  = b[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (mode == MODE_OVERRUN) begin
         in_valid = 1'b1;
         in_data  = 8'hCE;
      end
      if (mode == MODE_CLEAR) clear_stats = 1'b1;
      check("done_early", 32'(msg_done), 32'd0);
      @(posedge clk); #1;
      in_valid    = 1'b0;
      clear_stats = 1'b0;
      check("done_latency", 32'(msg_done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_msg_done"}, 32'(msg_done), 32'd0);
      check({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
      check({pfx, "_msg_class"}, 32'(msg_class), 32'd0);
      check({pfx, "_class_mismatch"}, 32'(class_mismatch), 32'd0);
      check({pfx, "_win_count"}, 32'(win_count), 32'd0);
      check({pfx, "_err_count"}, 32'(err_count), 32'd0);
      check({pfx, "_lock_count"}, 32'(lock_count), 32'd0);
      check({pfx, "_seg"}, 32'(seg), 32'h40);
   endtask

   task automatic check_counters(input string pfx);
      check({pfx, "_win_count"}, 32'(win_count), 32'(m_win));
      check({pfx, "_err_count"}, 32'(err_count), 32'(m_err));
      check({pfx, "_lock_count"}, 32'(lock_count), 32'(m_lock));
   endtask

   // Scoreboard monitor: compare each completed frame against its expectation.
   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (msg_done) begin
         done_cnt++;
         check("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("msg_class", 32'(msg_class), 32'(mon_e.cls));
            check("class_mismatch", 32'(class_mismatch), 32'(mon_e.mis));
            check("win_count", 32'(win_count), 32'(mon_e.win));
            check("err_count", 32'(err_count), 32'(mon_e.err));
            check("lock_count", 32'(lock_count), 32'(mon_e.lock));
            check("seg", 32'(seg), 32'(mon_e.seg));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      in_status   = 2'b00;
      clear_stats = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Clean win frame with matching status.
      send_frame(8'hCE, 8'hFA, 2'b10, -1, 8'h00, MODE_NORMAL);

      // Lockout frame while the game reports error: class kept, mismatch flagged.
      send_frame(8'hAD, 8'hDE, 2'b01, -1, 8'h00, MODE_NORMAL);

      // Frame broken after 10 bytes: one frame_err, no report, state unchanged.
      fe0 = fe_cnt;
      d0  = done_cnt;
      in_status = 2'b01;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = (i % 2 == 1) ? 8'hBA : 8'hD0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_msg_class_held", 32'(msg_class), 32'h3);
      check_counters("abort");

      // Full error frame after the abort.
      send_frame(8'hD0, 8'hBA, 2'b01, -1, 8'h00, MODE_NORMAL);

      // Error frame with byte 17 corrupted: unrecognized, no counter change.
      send_frame(8'hD0, 8'hBA, 2'b01, 17, 8'h00, MODE_NORMAL);

      // Byte offered during CHECK: one frame_err, byte ignored.
      fe0 = fe_cnt;
      send_frame(8'hCE, 8'hFA, 2'b10, -1, 8'h00, MODE_OVERRUN);
      repeat (3) @(posedge clk);
      #1;
      check("overrun_frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);

      // Unknown leading pair, then a lockout frame with matching status.
      send_frame(8'h11, 8'h22, 2'b10, -1, 8'h00, MODE_NORMAL);
      send_frame(8'hAD, 8'hDE, 2'b11, -1, 8'h00, MODE_NORMAL);

      // Counter saturation.
      repeat (260) send_frame(8'hCE, 8'hFA, 2'b10, -1, 8'h00, MODE_NORMAL);
      check("win_saturated", 32'(win_count), 32'hFF);
      check_counters("saturate");

      // clear_stats in the CHECK cycle overrides the increment.
      send_frame(8'hCE, 8'hFA, 2'b10, -1, 8'h00, MODE_CLEAR);
      check_counters("cleared");

      // Reset in the middle of a frame.
      in_status = 2'b10;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = (i % 2 == 1) ? 8'hFA : 8'hCE;
         @(posedge clk); #1;
      end
      fe0 = fe_cnt;
      d0  = done_cnt;
      rst     = 1'b1;
      in_data = 8'hCE;
      @(posedge clk); #1;
      check_reset_values("midframe_rst");
      m_win  = 8'd0;
      m_err  = 8'd0;
      m_lock = 8'd0;
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

      send_frame(8'hAD, 8'hDE, 2'b11, -1, 8'h00, MODE_NORMAL);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lockpick_result_monitor.md
LOCKPICK_RESULT_MONITOR -- requirements
Module: lockpick_result_monitor

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, result byte strobe from the game's output_valid.
REQ-004 SHALL have port in_data, input, 8, result byte from the game's output_data.
REQ-005 SHALL have port in_status, input, 2, the game's status (01 error, 10 win, 11 lockout).
REQ-006 SHALL have port clear_stats, input, 1, synchronous clear of all outcome counters.
REQ-007 SHALL have port msg_done, output, 1, one-cycle pulse marking a completed frame.
REQ-008 SHALL have port msg_class, output, 2, last frame class: 00 unrecognized, 01 error, 10 win, 11 lockout.
REQ-009 SHALL have port class_mismatch, output, 1, high with msg_done when msg_class is 00 or differs from the sampled in_status.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a framing violation.
REQ-011 SHALL have ports win_count, err_count and lock_count, output, 8 each, saturating outcome counters.
REQ-012 SHALL have port seg, output, 7, active-high {g,f,e,d,c,b,a} display of msg_class.

Function
REQ-013 SHALL implement FSM states WAIT, COLLECT, CHECK and REPORT.
REQ-014 WAIT: SHALL stay in WAIT while in_valid=0; in_valid=1 SHALL accept byte 0, sample in_status, set idx=1 and go to COLLECT.
REQ-015 COLLECT: each in_valid=1 cycle SHALL accept a byte and increment idx (5-bit); the 32nd byte (idx=31) SHALL move the FSM to CHECK.
REQ-016 COLLECT: in_valid=0 SHALL pulse frame_err, discard the partial frame, leave counters and msg_class unchanged, and return to WAIT.
REQ-017 Patterns, period 2 (even idx / odd idx): win CE/FA, error D0/BA, lockout AD/DE.
REQ-018 Candidate class SHALL be fixed by bytes 0 and 1; any later byte differing from the candidate pattern SHALL set a sticky mismatch, making the class 00.
REQ-019 CHECK (one cycle): SHALL register msg_class and class_mismatch and increment the matching counter; class 00 SHALL increment no counter.
REQ-020 REPORT (one cycle): msg_done SHALL be 1, then the FSM SHALL return to WAIT.
REQ-021 Latency: if the 32nd byte is sampled at edge k, msg_done SHALL be high in the cycle after edge k+1.
REQ-022 msg_class and class_mismatch SHALL hold until the next CHECK.
REQ-023 in_valid=1 during CHECK or REPORT SHALL pulse frame_err; that byte SHALL be ignored.
REQ-024 Counters SHALL saturate at 255; clear_stats SHALL zero all three and SHALL take priority over a simultaneous increment.
REQ-025 seg SHALL show '-' 0x40 from reset until the first CHECK, then: 10->0x73 'P', 01->0x79 'E', 11->0x38 'L', 00->0x3E 'U'.

Reset
REQ-026 rst SHALL force state WAIT, idx 0, mismatch 0, msg_done 0, frame_err 0, msg_class 00, class_mismatch 0, all counters 0, and seg 0x40.
REQ-027 rst SHALL win over every other input in the same cycle, including mid-COLLECT, and SHALL produce no msg_done or frame_err pulse.

Structure
REQ-028 Package lockpick_pkg SHALL hold the FSM state enum, the class encoding, FRAME_LEN=32, and the six pattern byte constants.
REQ-029 The 7-segment decode SHALL be a combinational sub-module, lockpick_seg7, driven by msg_class plus a shown-since-reset flag.

Verification
REQ-030 32 contiguous bytes CE,FA,... with in_status=10 -> msg_done two cycles after the last byte, msg_class=10, class_mismatch=0, win_count=1, seg=0x73.
REQ-031 32 bytes AD,DE,... with in_status=01 -> msg_class=11, class_mismatch=1, lock_count=1, seg=0x38.
REQ-032 in_valid drops after 10 bytes -> one frame_err pulse, no msg_done, counters unchanged; a following full D0,BA frame -> msg_class=01, err_count=1.
REQ-033 Error frame with byte 17 = 00 -> msg_class=00, class_mismatch=1, seg=0x3E, no counter change.
REQ-034 260 win frames -> win_count=255; clear_stats asserted in a CHECK cycle -> all counters 0 afterwards.
REQ-035 rst asserted at byte 20 of a frame -> all REQ-026 values next cycle; the next full frame classifies correctly.
